shift_pipe_ctrl: RTL and testbench
==================================

Name: shift_pipe_ctrl

Overview:
- Pipelined control stage wrapped around the 32-bit combinational shifter datapath.
- Accepts shift requests on a valid/ready input port and buffers them in a 2-entry skid buffer.
- Registers the operands that drive the combinational shift, decodes and clamps the shift amount, then captures the result with status flags for the downstream writeback consumer.
- Gives the shifter a registered, back-pressure-safe neighbour, so the shifter itself stays purely combinational.

Parameters:
- WIDTH, 32, data width of operands and result; must be a power of two.
- SKID_DEPTH, 2, input buffer entries; fixed at 2 for this revision.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  registered; high when the skid buffer holds fewer than 2 entries.
- in_a  input  WIDTH  value to shift, treated as signed.
- in_b  input  WIDTH  shift amount, unsigned.
- in_op  input  2  00 SRA, 01 SRL, 10 SLL, 11 ROR.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_result  output  WIDTH  shifted value.
- out_zero  output  1  out_result == 0.
- out_neg  output  1  out_result[WIDTH-1].
- out_op  output  2  opcode of the result, echoed.

Behaviour:
- Reset (asynchronous, rst_n low): skid buffer empty, in_ready=1, out_valid=0, out_result=0, out_zero=0, out_neg=0, out_op=00, operand stage invalid.
- Handshake:
  - Transfer on in_valid&&in_ready, or on out_valid&&out_ready.
  - in_* are sampled only on a transfer.
  - out_* are held stable while out_valid&&!out_ready.
- Pipeline: skid buffer (FIFO order) -> operand register (S1) -> combinational shift -> result register (S2).
- Latency with no stall: request accepted at edge N gives out_valid high after edge N+2.
- Throughput: 1 op per cycle.
- Advance rules:
  - S2 loads when S2 is empty or out_ready=1.
  - S1 loads from the buffer head when S1 is empty or S1 moves into S2.
  - A simultaneous push and pop leaves the buffer count unchanged.
- Capacity: with out_ready held low, exactly 4 requests are accepted (S2, S1, 2 skid entries); in_ready then deasserts.
- in_ready is a register: it reflects the count after the current edge and has no combinational in_valid->in_ready path.
- Amount clamp, decided in S1:
  - SRA with in_b >= WIDTH gives all bits equal to the sign bit.
  - SRL/SLL with in_b >= WIDTH gives 0.
  - ROR uses in_b[log2(WIDTH)-1:0] only.
  - in_b == 0 gives in_a unchanged for every op.
- Flags are computed from the S2-registered result and are valid only with out_valid.
- Reset mid-operation discards all buffered and in-flight ops; no partial result ever appears.
- in_valid asserted while in_ready=0 is ignored; the request is not captured and the upstream holds it.

Optional Feature:
- Macro SHIFT_PIPE_STATS_EN.
- When defined, adds two 32-bit output ports:
  - stat_ops: count of accepted requests.
  - stat_stall: count of cycles with out_valid&&!out_ready.
- Both counters reset to 0 on rst_n, wrap modulo 2^32, and update on the same edge as the event.
- When undefined, the ports and counters are absent and all other behaviour is identical.

Decomposition:
- Package shift_pkg:
  - WIDTH default constant.
  - 2-bit opcode typedef with named values SRA/SRL/SLL/ROR.
  - Request struct {a, b, op}.
- One sub-module, shift_skid_buf: 2-entry FIFO holding request structs, with registered not-full output and valid/ready on both sides.
- The shift itself is combinational logic in the S1->S2 path, matching the existing shifter semantics.

Test Plan:
- SRA 0x80000000 by 4, out_ready=1 -> after 2 edges out_result=0xF8000000, out_neg=1, out_zero=0.
- SRA 0x80000000 by 40 -> 0xFFFFFFFF; SRA 0x7FFFFFFF by 40 -> 0x00000000, out_zero=1.
- SRL 0x80000000 by 31 -> 0x00000001; SLL 0x00000001 by 32 -> 0x00000000, out_zero=1; ROR 0x00000001 by 33 -> 0x80000000.
- Back-pressure:
  - Hold out_ready=0 and drive 6 back-to-back requests with a=1..6, SLL by 0.
  - Required: exactly 4 accepted and in_ready low.
  - Then raise out_ready: results 1,2,3,4 in order, then 5,6 accepted and delivered, with no loss or duplication.
- Drop rst_n low mid-stream with 3 ops in flight -> out_valid=0 and in_ready=1 immediately (asynchronous); after release the first new op appears 2 edges after acceptance.
- With SHIFT_PIPE_STATS_EN, the back-pressure scenario holding out_ready low for 5 cycles with out_valid high -> stat_stall=5, stat_ops=6 at the end.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and shift semantics for the shift pipeline control stage.
// Holds the default width, opcode encoding, request struct and combinational shift function.
package shift_pkg;

   localparam int WIDTH = 32;
   localparam int SHW   = $clog2(WIDTH);

   typedef enum logic [1:0] {
      SRA = 2'b00,
      SRL = 2'b01,
      SLL = 2'b10,
      ROR = 2'b11
   } shift_op_e;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      shift_op_e        op;
   } shift_req_t;

   // Any set bit above the amount field means "shifted out entirely", except for ROR.
   function automatic logic [WIDTH-1:0] shift_calc(input shift_req_t req);
      logic               over;
      logic [SHW-1:0]     amt;
      logic [2*WIDTH-1:0] dbl;
      logic [WIDTH-1:0]   res;
      over = |req.b[WIDTH-1:SHW];
      amt  = req.b[SHW-1:0];
      dbl  = {req.a, req.a} >> amt;
      case (req.op)
         SRA:     res = over ? {WIDTH{req.a[WIDTH-1]}} : WIDTH'($signed(req.a) >>> amt);
         SRL:     res = over ? {WIDTH{1'b0}} : (req.a >> amt);
         SLL:     res = over ? {WIDTH{1'b0}} : (req.a << amt);
         ROR:     res = dbl[WIDTH-1:0];
         default: res = req.a;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/shift_skid_buf.sv
// Two-entry request FIFO in front of the operand register; not-full is registered
// so the upstream never sees a combinational valid->ready path.
module shift_skid_buf
   import shift_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push_valid,
   output logic       push_ready,
   input  shift_req_t push_data,
   output logic       pop_valid,
   input  logic       pop_ready,
   output shift_req_t pop_data
);

   shift_req_t mem_r [2];
   logic       wr_ptr_r;
   logic       rd_ptr_r;
   logic [1:0] count_r;
   logic       push_s;
   logic       pop_s;
   logic [1:0] count_next_s;

   assign pop_valid = (count_r != 2'd0);
   assign pop_data  = mem_r[rd_ptr_r];

   // Handshake qualification and next occupancy.
   always_comb begin
      push_s       = push_valid && push_ready;
      pop_s        = pop_valid && pop_ready;
      count_next_s = count_r + {1'b0, push_s} - {1'b0, pop_s};
   end

   // Storage, pointers, occupancy and registered not-full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_r[0]   <= '0;
         mem_r[1]   <= '0;
         wr_ptr_r   <= 1'b0;
         rd_ptr_r   <= 1'b0;
         count_r    <= 2'd0;
         push_ready <= 1'b1;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= ~wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         count_r    <= count_next_s;
         push_ready <= (count_next_s != 2'(DEPTH));
      end
   end

endmodule

// File: rtl/shift_pipe_ctrl.sv
// Pipelined control stage around the combinational shifter: skid buffer -> S1 operands -> S2 result.
// Optional macro SHIFT_PIPE_STATS_EN adds stat_ops / stat_stall counters.
module shift_pipe_ctrl #(
   parameter int WIDTH      = shift_pkg::WIDTH,
   parameter int SKID_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_neg,
   output logic [1:0]       out_op
`ifdef SHIFT_PIPE_STATS_EN
   ,
   output logic [31:0]      stat_ops,
   output logic [31:0]      stat_stall
`endif
);
   import shift_pkg::*;

   shift_req_t       in_req_s;
   shift_req_t       head_s;
   shift_req_t       s1_req_r;
   logic             head_valid_s;
   logic             pop_ready_s;
   logic             s1_valid_r;
   logic             s2_load_s;
   logic [WIDTH-1:0] shift_res_s;

   assign in_req_s = '{a: in_a, b: in_b, op: shift_op_e'(in_op)};

   shift_skid_buf #(
      .DEPTH      (SKID_DEPTH)
   ) u_skid (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_valid (in_valid),
      .push_ready (in_ready),
      .push_data  (in_req_s),
      .pop_valid  (head_valid_s),
      .pop_ready  (pop_ready_s),
      .pop_data   (head_s)
   );

   // Advance conditions and the combinational shift between S1 and S2.
   always_comb begin
      s2_load_s   = !out_valid || out_ready;
      pop_ready_s = !s1_valid_r || s2_load_s;
      shift_res_s = shift_calc(s1_req_r);
   end

   // S1: operand register fed from the buffer head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_req_r   <= '0;
      end else if (pop_ready_s) begin
         s1_valid_r <= head_valid_s;
         if (head_valid_s) begin
            s1_req_r <= head_s;
         end
      end
   end

   // S2: result and flags, held while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_result <= '0;
         out_zero   <= 1'b0;
         out_neg    <= 1'b0;
         out_op     <= 2'b00;
      end else if (s2_load_s) begin
         out_valid <= s1_valid_r;
         if (s1_valid_r) begin
            out_result <= shift_res_s;
            out_zero   <= (shift_res_s == '0);
            out_neg    <= shift_res_s[WIDTH-1];
            out_op     <= s1_req_r.op;
         end
      end
   end

`ifdef SHIFT_PIPE_STATS_EN
   // Accepted-request and stall-cycle counters, wrapping modulo 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_ops   <= 32'd0;
         stat_stall <= 32'd0;
      end else begin
         if (in_valid && in_ready) begin
            stat_ops <= stat_ops + 32'd1;
         end
         if (out_valid && !out_ready) begin
            stat_stall <= stat_stall + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_shift_pipe_ctrl.sv
// Scoreboard bench for shift_pipe_ctrl: driver pushes hand-computed results, negedge monitor pops and compares.
module tb_shift_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = 32'd0;
   logic [31:0] in_b = 32'd0;
   logic [1:0]  in_op = 2'b00;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;
   logic        out_zero;
   logic        out_neg;
   logic [1:0]  out_op;
`ifdef SHIFT_PIPE_STATS_EN
   logic [31:0] stat_ops;
   logic [31:0] stat_stall;
`endif

   always #5 clk = ~clk;

   shift_pipe_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_op      (in_op),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_zero   (out_zero),
      .out_neg    (out_neg),
      .out_op     (out_op)
`ifdef SHIFT_PIPE_STATS_EN
      ,
      .stat_ops   (stat_ops),
      .stat_stall (stat_stall)
`endif
   );

   typedef struct {
      logic [31:0] res;
      logic [1:0]  op;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  op;
      logic [31:0] res;
   } tv_t;

   tv_t tv [0:14] = '{
      '{32'h80000000, 32'd4,  2'b00, 32'hF8000000},
      '{32'h80000000, 32'd40, 2'b00, 32'hFFFFFFFF},
      '{32'h7FFFFFFF, 32'd40, 2'b00, 32'h00000000},
      '{32'h80000000, 32'd31, 2'b01, 32'h00000001},
      '{32'h00000001, 32'd32, 2'b10, 32'h00000000},
      '{32'h00000001, 32'd33, 2'b11, 32'h80000000},
      '{32'h12345678, 32'd4,  2'b00, 32'h01234567},
      '{32'h12345678, 32'd8,  2'b11, 32'h78123456},
      '{32'h0000FFFF, 32'd16, 2'b10, 32'hFFFF0000},
      '{32'h80000000, 32'd32, 2'b01, 32'h00000000},
      '{32'h12345678, 32'd0,  2'b11, 32'h12345678},
      '{32'h80000000, 32'd0,  2'b00, 32'h80000000},
      '{32'h80000000, 32'd31, 2'b00, 32'hFFFFFFFF},
      '{32'h00000003, 32'd31, 2'b10, 32'h80000000},
      '{32'h80000001, 32'd32, 2'b11, 32'h80000001}
   };

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   ops_exp = 0;
   int   stall_exp = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Call at a negedge; returns at the negedge after the accepting posedge.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       input logic [31:0] res);
      int   n;
      exp_t e;
      n        = 0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_op    = op;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("accept_timeout", 32'(in_ready), 32'd1);
      end else begin
         e.res = res;
         e.op  = op;
         sb_q.push_back(e);
         ops_exp++;
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(sb_q.size()), 32'd0);
   endtask

   // Monitor: a transfer happens at the next posedge whenever out_valid && out_ready here.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=%h required=none", out_result);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("result", out_result, e.res);
            check("zero", 32'(out_zero), 32'(e.res == 32'd0));
            check("neg", 32'(out_neg), 32'(e.res[31]));
            check("op", 32'(out_op), 32'(e.op));
         end
      end
      if (rst_n && out_valid && !out_ready) begin
         stall_exp++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      longint t0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_result", out_result, 32'd0);
      check("rst_out_zero", 32'(out_zero), 32'd0);
      check("rst_out_neg", 32'(out_neg), 32'd0);
      check("rst_out_op", 32'(out_op), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Two-edge latency, then a back-to-back stream at full rate.
      out_ready = 1'b1;
      send(tv[0].a, tv[0].b, tv[0].op, tv[0].res);
      check("lat_edge_n", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("lat_edge_n1", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("lat_edge_n2", 32'(out_valid), 32'd1);
      t0 = $time;
      for (int i = 1; i < 15; i++) begin
         send(tv[i].a, tv[i].b, tv[i].op, tv[i].res);
      end
      check("throughput_cycles", 32'(($time - t0) / 10), 32'd14);
      drain("drain_vectors");

      // Back-pressure: four accepted, the fifth held off.
      out_ready = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         send(32'(k), 32'd0, 2'b10, 32'(k));
      end
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      in_valid = 1'b1;
      in_a     = 32'd5;
      in_b     = 32'd0;
      in_op    = 2'b10;
      repeat (2) @(negedge clk);
      check("bp_still_full", 32'(in_ready), 32'd0);
      check("bp_held_valid", 32'(out_valid), 32'd1);
      check("bp_held_result", out_result, 32'd1);
      out_ready = 1'b1;
      send(32'd5, 32'd0, 2'b10, 32'd5);
      send(32'd6, 32'd0, 2'b10, 32'd6);
      drain("drain_backpressure");
      @(negedge clk);
`ifdef SHIFT_PIPE_STATS_EN
      check("stat_ops", stat_ops, 32'(ops_exp));
      check("stat_stall", stat_stall, 32'(stall_exp));
`endif

      // Asynchronous reset with three ops in flight.
      out_ready = 1'b0;
      send(32'h00000070, 32'd1, 2'b01, 32'h00000038);
      send(32'h00000080, 32'd1, 2'b01, 32'h00000040);
      send(32'h00000090, 32'd1, 2'b01, 32'h00000048);
      check("pre_reset_valid", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", 32'(out_valid), 32'd0);
      check("async_rst_in_ready", 32'(in_ready), 32'd1);
      sb_q.delete();
      ops_exp   = 0;
      stall_exp = 0;
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check("post_rst_idle", 32'(out_valid), 32'd0);
      send(32'hFFFF0000, 32'd8, 2'b00, 32'hFFFFFF00);
      check("post_lat_n", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("post_lat_n1", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("post_lat_n2", 32'(out_valid), 32'd1);
      drain("drain_post_reset");
      @(negedge clk);
      check("final_idle", 32'(out_valid), 32'd0);
`ifdef SHIFT_PIPE_STATS_EN
      check("stat_ops_post_rst", stat_ops, 32'(ops_exp));
      check("stat_stall_post_rst", stat_stall, 32'(stall_exp));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
